// File: rtl/writeback_unit_pkg.sv
// Shared definitions for the writeback unit: datapath widths, the zero
// register index, the result record and the per-cycle write-source select.
package writeback_unit_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

   // One completed result travelling toward the register file.
   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_result_t;

   // Source chosen for the register-file write in the current cycle.
   typedef enum logic [1:0] {
      SEL_NONE = 2'd0,
      SEL_ALU  = 2'd1,
      SEL_SKID = 2'd2,
      SEL_LSU  = 2'd3
   } wb_sel_e;

   // One-hot mask for a register index; the zero register never gets a bit.
   function automatic logic [NUM_REGS-1:0] reg_mask(input logic [REG_ADDR_W-1:0] idx);
      logic [NUM_REGS-1:0] m;
      m = {NUM_REGS{1'b0}};
      if (idx != ZERO_REG) begin
         m[idx] = 1'b1;
      end else begin
         m = {NUM_REGS{1'b0}};
      end
      return m;
   endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register that marks an
// outstanding long-latency result. Set has priority over clear on the same
// edge, and register 0 is never marked.
module wb_scoreboard
   import writeback_unit_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  set_en,
   input  logic [REG_ADDR_W-1:0] set_addr,
   input  logic                  clr_en,
   input  logic [REG_ADDR_W-1:0] clr_addr,
   input  logic [REG_ADDR_W-1:0] rs1,
   input  logic [REG_ADDR_W-1:0] rs2,
   input  logic [REG_ADDR_W-1:0] rd,
   output logic [NUM_REGS-1:0]   pending,
   output logic                  hit_rs1,
   output logic                  hit_rs2,
   output logic                  hit_rd
);

   logic [NUM_REGS-1:0] pending_r;
   logic [NUM_REGS-1:0] set_mask_s;
   logic [NUM_REGS-1:0] clr_mask_s;

   // Build set/clear masks for this edge from the strobes.
   always_comb begin
      set_mask_s = {NUM_REGS{1'b0}};
      clr_mask_s = {NUM_REGS{1'b0}};
      if (set_en) begin
         set_mask_s = reg_mask(set_addr);
      end else begin
         set_mask_s = {NUM_REGS{1'b0}};
      end
      if (clr_en) begin
         clr_mask_s = reg_mask(clr_addr);
      end else begin
         clr_mask_s = {NUM_REGS{1'b0}};
      end
   end

   // Scoreboard state: clear first, then OR in the set so set wins a race.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_r <= {NUM_REGS{1'b0}};
      end else begin
         pending_r <= ((pending_r & ~clr_mask_s) | set_mask_s) & {{(NUM_REGS-1){1'b1}}, 1'b0};
      end
   end

   assign pending = pending_r;
   assign hit_rs1 = pending_r[rs1];
   assign hit_rs2 = pending_r[rs2];
   assign hit_rd  = pending_r[rd];

endmodule

// File: rtl/writeback_unit.sv
// Writeback unit: merges the single-cycle ALU result and the long-latency LSU
// result into one register-file write port. An LSU result arriving alongside
// an ALU result is parked in a one-entry skid buffer and written next.
// The retire counter exists only when WB_INSTRET_EN is defined; otherwise
// instret is tied to zero.
module writeback_unit
   import writeback_unit_pkg::*;
#(
   parameter int CNT_W = 64
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  alu_valid,
   input  logic [REG_ADDR_W-1:0] alu_rd,
   input  logic [XLEN-1:0]       alu_data,
   input  logic                  lsu_valid,
   output logic                  lsu_ready,
   input  logic [REG_ADDR_W-1:0] lsu_rd,
   input  logic [XLEN-1:0]       lsu_data,
   input  logic                  iss_long_valid,
   input  logic [REG_ADDR_W-1:0] iss_long_rd,
   input  logic [REG_ADDR_W-1:0] dec_rs1,
   input  logic [REG_ADDR_W-1:0] dec_rs2,
   input  logic [REG_ADDR_W-1:0] dec_rd,
   output logic                  dec_stall,
   output logic                  w_enabled,
   output logic [REG_ADDR_W-1:0] w_addr,
   output logic [XLEN-1:0]       w_data,
   output logic [NUM_REGS-1:0]   pending,
   output logic [CNT_W-1:0]      instret
);

   logic                  skid_full_r;
   wb_result_t            skid_r;
   logic                  hs_s;
   wb_sel_e               sel_s;
   wb_result_t            sel_res_s;
   logic                  clr_en_s;
   logic                  w_enabled_r;
   logic [REG_ADDR_W-1:0] w_addr_r;
   logic [XLEN-1:0]       w_data_r;
   logic                  hit_rs1_s;
   logic                  hit_rs2_s;
   logic                  hit_rd_s;

   // The LSU may only hand over a result when the skid can absorb it.
   assign lsu_ready = ~skid_full_r & ~rst;
   assign hs_s      = lsu_valid & lsu_ready;

   // Pick the write source: ALU first, then the parked skid, then direct LSU.
   always_comb begin
      sel_s = SEL_NONE;
      if (alu_valid) begin
         sel_s = SEL_ALU;
      end else if (skid_full_r) begin
         sel_s = SEL_SKID;
      end else if (hs_s) begin
         sel_s = SEL_LSU;
      end else begin
         sel_s = SEL_NONE;
      end
   end

   // Route the selected result onto the write datapath.
   always_comb begin
      sel_res_s = '{rd: ZERO_REG, data: 32'd0};
      case (sel_s)
         SEL_ALU:  sel_res_s = '{rd: alu_rd, data: alu_data};
         SEL_SKID: sel_res_s = skid_r;
         SEL_LSU:  sel_res_s = '{rd: lsu_rd, data: lsu_data};
         SEL_NONE: sel_res_s = '{rd: ZERO_REG, data: 32'd0};
         default:  sel_res_s = '{rd: ZERO_REG, data: 32'd0};
      endcase
   end

   // Skid buffer: park an LSU result that lost to the ALU, release on drain.
   always_ff @(posedge clk) begin
      if (rst) begin
         skid_full_r <= 1'b0;
         skid_r      <= '{rd: ZERO_REG, data: 32'd0};
      end else if (alu_valid && hs_s) begin
         skid_full_r <= 1'b1;
         skid_r      <= '{rd: lsu_rd, data: lsu_data};
      end else if (sel_s == SEL_SKID) begin
         skid_full_r <= 1'b0;
         skid_r      <= skid_r;
      end else begin
         skid_full_r <= skid_full_r;
         skid_r      <= skid_r;
      end
   end

   // Registered write port; a result aimed at x0 is consumed without a strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         w_enabled_r <= 1'b0;
         w_addr_r    <= ZERO_REG;
         w_data_r    <= 32'd0;
      end else if (sel_s != SEL_NONE) begin
         w_enabled_r <= (sel_res_s.rd != ZERO_REG);
         w_addr_r    <= sel_res_s.rd;
         w_data_r    <= sel_res_s.data;
      end else begin
         w_enabled_r <= 1'b0;
         w_addr_r    <= w_addr_r;
         w_data_r    <= w_data_r;
      end
   end

   assign w_enabled = w_enabled_r;
   assign w_addr    = w_addr_r;
   assign w_data    = w_data_r;

   // Long-latency results retire their pending bit on the edge they are written.
   assign clr_en_s = (sel_s == SEL_SKID) || (sel_s == SEL_LSU);

   wb_scoreboard u_scoreboard (
      .clk      (clk),
      .rst      (rst),
      .set_en   (iss_long_valid),
      .set_addr (iss_long_rd),
      .clr_en   (clr_en_s),
      .clr_addr (sel_res_s.rd),
      .rs1      (dec_rs1),
      .rs2      (dec_rs2),
      .rd       (dec_rd),
      .pending  (pending),
      .hit_rs1  (hit_rs1_s),
      .hit_rs2  (hit_rs2_s),
      .hit_rd   (hit_rd_s)
   );

   assign dec_stall = (hit_rs1_s | hit_rs2_s | hit_rd_s) & ~rst;

`ifdef WB_INSTRET_EN
   logic [CNT_W-1:0] instret_r;
   logic [CNT_W-1:0] retire_inc_s;

   assign retire_inc_s = {{(CNT_W-1){1'b0}}, alu_valid} + {{(CNT_W-1){1'b0}}, hs_s};

   // Retire counter: every consumed result counts, x0 writes included.
   always_ff @(posedge clk) begin
      if (rst) begin
         instret_r <= {CNT_W{1'b0}};
      end else begin
         instret_r <= instret_r + retire_inc_s;
      end
   end

   assign instret = instret_r;
`else
   assign instret = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// queue-based behavioural model.
module tb_writeback_unit;

   logic        clk;
   logic        rst;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        lsu_valid;
   logic        lsu_ready;
   logic [4:0]  lsu_rd;
   logic [31:0] lsu_data;
   logic        iss_long_valid;
   logic [4:0]  iss_long_rd;
   logic [4:0]  dec_rs1;
   logic [4:0]  dec_rs2;
   logic [4:0]  dec_rd;
   logic        dec_stall;
   logic        w_enabled;
   logic [4:0]  w_addr;
   logic [31:0] w_data;
   logic [31:0] pending;
   logic [63:0] instret;

   writeback_unit #(.CNT_W(64)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
      .iss_long_valid(iss_long_valid), .iss_long_rd(iss_long_rd),
      .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .dec_stall(dec_stall),
      .w_enabled(w_enabled), .w_addr(w_addr), .w_data(w_data),
      .pending(pending), .instret(instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [4:0]  rd;
      logic [31:0] d;
   } res_t;

   res_t        backlog[$];   // LSU results accepted but not yet written
   logic [31:0] m_pend;
   logic        m_we;
   logic [4:0]  m_wa;
   logic [31:0] m_wd;
   logic [63:0] m_ir;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Record a write of one result into the model's expected port value.
   task automatic model_write(input logic [4:0] rd, input logic [31:0] d);
      m_we = (rd != 5'd0);
      if (rd != 5'd0) begin
         m_wa = rd;
         m_wd = d;
      end
   endtask

   // Advance the model by one clock using the inputs present at the edge.
   task automatic model_step();
      logic accept;
      logic lsu_written;
      res_t r;
      if (rst) begin
         backlog.delete();
         m_pend = 32'd0;
         m_we   = 1'b0;
         m_wa   = 5'd0;
         m_wd   = 32'd0;
         m_ir   = 64'd0;
      end else begin
         accept      = lsu_valid && (backlog.size() == 0);
         lsu_written = 1'b0;
         r.rd = 5'd0;
         r.d  = 32'd0;
         if (alu_valid) begin
            model_write(alu_rd, alu_data);
            if (accept) backlog.push_back('{rd: lsu_rd, d: lsu_data});
         end else if (backlog.size() > 0) begin
            r = backlog.pop_front();
            model_write(r.rd, r.d);
            lsu_written = 1'b1;
         end else if (accept) begin
            r.rd = lsu_rd;
            r.d  = lsu_data;
            model_write(r.rd, r.d);
            lsu_written = 1'b1;
         end else begin
            m_we = 1'b0;
         end
         if (lsu_written) m_pend[r.rd] = 1'b0;
         if (iss_long_valid && iss_long_rd != 5'd0) m_pend[iss_long_rd] = 1'b1;
         m_ir = m_ir + 64'(alu_valid) + 64'(accept);
      end
   endtask

   // Compare every DUT output against the model for the current cycle.
   task automatic check_all();
      logic exp_ready;
      logic exp_stall;
      exp_ready = !rst && (backlog.size() == 0);
      exp_stall = !rst && (m_pend[dec_rs1] || m_pend[dec_rs2] || m_pend[dec_rd]);
      chk("lsu_ready", 64'(lsu_ready), 64'(exp_ready));
      chk("dec_stall", 64'(dec_stall), 64'(exp_stall));
      chk("pending",   64'(pending),   64'(m_pend));
      chk("w_enabled", 64'(w_enabled), 64'(m_we));
      if (m_we) begin
         chk("w_addr", 64'(w_addr), 64'(m_wa));
         chk("w_data", 64'(w_data), 64'(m_wd));
      end
`ifdef WB_INSTRET_EN
      chk("instret", instret, m_ir);
`else
      chk("instret", instret, 64'd0);
`endif
   endtask

   // Drive one cycle of inputs (called at a negedge), check, clock the model,
   // and return at the following negedge with the inputs still applied.
   task automatic step(input logic r, input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                       input logic iv, input logic [4:0] ird,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d);
      rst = r; alu_valid = av; alu_rd = ard; alu_data = ad;
      lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
      iss_long_valid = iv; iss_long_rd = ird;
      dec_rs1 = s1; dec_rs2 = s2; dec_rd = d;
      #1;
      check_all();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
   endtask

   initial begin
      rst = 1'b1; alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
      lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 32'd0;
      iss_long_valid = 1'b0; iss_long_rd = 5'd0;
      dec_rs1 = 5'd0; dec_rs2 = 5'd0; dec_rd = 5'd0;
      @(posedge clk);
      model_step();
      @(negedge clk);

      // Reset state
      step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
      chk("rst_w_enabled", 64'(w_enabled), 64'd0);
      chk("rst_w_addr",    64'(w_addr),    64'd0);
      chk("rst_w_data",    64'(w_data),    64'd0);
      chk("rst_pending",   64'(pending),   64'd0);
      chk("rst_lsu_ready", 64'(lsu_ready), 64'd0);
      chk("rst_dec_stall", 64'(dec_stall), 64'd0);
      chk("rst_instret",   instret,        64'd0);

      // ALU only
      step(1'b0, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
      chk("alu_we",   64'(w_enabled), 64'd1);
      chk("alu_addr", 64'(w_addr),    64'd5);
      chk("alu_data", 64'(w_data),    64'h1234);

      // Collision: ALU wins, LSU parked then written
      step(1'b0, 1'b1, 5'd3, 32'hA, 1'b1, 5'd4, 32'hB, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
      chk("col1_we",    64'(w_enabled), 64'd1);
      chk("col1_addr",  64'(w_addr),    64'd3);
      chk("col1_data",  64'(w_data),    64'hA);
      chk("col1_ready", 64'(lsu_ready), 64'd0);
      idle();
      chk("col2_we",   64'(w_enabled), 64'd1);
      chk("col2_addr", 64'(w_addr),    64'd4);
      chk("col2_data", 64'(w_data),    64'hB);

      // Scoreboard stall on rd=7
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd0, 5'd0);
      chk("sb_pend7", 64'(pending[7]), 64'd1);
      chk("sb_stall", 64'(dec_stall),  64'd1);
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd0, 5'd0);
      chk("sb_stall_hold", 64'(dec_stall), 64'd1);
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 5'd7, 5'd0, 5'd0);
      chk("sb_wr_we",   64'(w_enabled), 64'd1);
      chk("sb_wr_addr", 64'(w_addr),    64'd7);
      chk("sb_drop",    64'(dec_stall), 64'd0);

      // Set/clear race on rd=7
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd0, 5'd0, 5'd0);
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h71, 1'b1, 5'd7, 5'd0, 5'd0, 5'd0);
      chk("race_we",    64'(w_enabled),  64'd1);
      chk("race_pend7", 64'(pending[7]), 64'd1);
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h72, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
      chk("race_clear", 64'(pending[7]), 64'd0);

      // rd=0 LSU result is consumed without a strobe
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
      chk("x0_we", 64'(w_enabled), 64'd0);
`ifdef WB_INSTRET_EN
      chk("x0_instret", instret, 64'd7);
`else
      chk("x0_instret", instret, 64'd0);
`endif

      // Reset with skid full and pending[9]
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd0, 5'd0, 5'd0);
      step(1'b0, 1'b1, 5'd1, 32'd1, 1'b1, 5'd2, 32'd2, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
      chk("pre_rst_ready", 64'(lsu_ready), 64'd0);
      chk("pre_rst_pend9", 64'(pending[9]), 64'd1);
      step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
      chk("mid_rst_pending", 64'(pending), 64'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_ready", 64'(lsu_ready), 64'd1);
      idle();
      chk("post_rst_no_drain", 64'(w_enabled), 64'd0);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         logic [4:0] a_rd;
         logic [4:0] l_rd;
         logic [4:0] i_rd;
         a_rd = 5'($urandom_range(0, 31));
         l_rd = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
         i_rd = 5'($urandom_range(0, 7));
         step(($urandom_range(0, 63) == 0),
              ($urandom_range(0, 1) == 1), a_rd, $urandom,
              ($urandom_range(0, 1) == 1), l_rd, $urandom,
              ($urandom_range(0, 2) == 0), i_rd,
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end
      idle();
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameter CNT_W, default 64: width of the retire counter.
REQ-002 clk  in  1  sole clock; all state updates on posedge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 alu_valid  in  1  single-cycle ALU result present this cycle.
REQ-005 alu_rd  in  5  ALU destination register.
REQ-006 alu_data  in  32  ALU result.
REQ-007 lsu_valid  in  1  long-latency (load/div) result offered.
REQ-008 lsu_ready  out  1  unit accepts the LSU result this cycle.
REQ-009 lsu_rd  in  5  LSU destination register.
REQ-010 lsu_data  in  32  LSU result.
REQ-011 iss_long_valid  in  1  long-latency op issued this cycle.
REQ-012 iss_long_rd  in  5  destination of the issued long op.
REQ-013 dec_rs1, dec_rs2, dec_rd  in  5 each  decode-stage operand/destination addresses.
REQ-014 dec_stall  out  1  decode must hold.
REQ-015 w_enabled  out  1  register-file write strobe.
REQ-016 w_addr  out  5  register-file write address.
REQ-017 w_data  out  32  register-file write data.
REQ-018 pending  out  32  scoreboard bits, debug.
REQ-019 instret  out  CNT_W  retire count (see Configuration).

Function
REQ-020 LSU handshake occurs when lsu_valid and lsu_ready are both 1; lsu_ready SHALL equal NOT skid_full AND NOT rst.
REQ-021 One-entry skid buffer SHALL hold an LSU result accepted in a cycle where alu_valid is 1.
REQ-022 Write select priority per cycle: ALU, then skid entry, then direct LSU handshake; exactly one result written per cycle at most.
REQ-023 Skid behaviour: alu_valid plus handshake loads skid; skid full, no alu_valid, skid drains; skid empty, no alu_valid, handshake writes directly.
REQ-024 Selected result SHALL appear on w_addr/w_data with w_enabled=1 exactly one cycle after selection (registered outputs).
REQ-025 Result with rd=0 SHALL be consumed with w_enabled=0.
REQ-026 Scoreboard: bit rd set on iss_long_valid with rd!=0; bit cleared on the edge that loads the LSU or skid result into w_*.
REQ-027 Simultaneous set and clear of the same bit: set wins; bit 0 never set.
REQ-028 dec_stall = pending[dec_rs1] OR pending[dec_rs2] OR pending[dec_rd], combinational; the register file's write-through covers the cycle after clear.
REQ-029 ALU results never check the scoreboard; decode stalling guarantees no ALU write to a pending register.

Reset
REQ-030 While rst=1: w_enabled=0, w_addr=0, w_data=0, skid empty, pending=0, lsu_ready=0, instret=0, dec_stall=0.
REQ-031 Reset mid-operation discards skid contents and all pending bits in the same edge.

Configuration
REQ-032 Macro WB_INSTRET_EN defined: instret increments by the number of results consumed per cycle (0, 1 or 2: alu_valid plus handshake), including rd=0, wrapping modulo 2^CNT_W.
REQ-033 Macro undefined: no counter logic; instret tied to 0.

Structure
REQ-034 XLEN=32, REG_ADDR_W=5 and ZERO_REG constants SHALL live in the shared def package.
REQ-035 Scoreboard SHALL be sub-module wb_scoreboard (set/clear ports, 32-bit state, three lookups).

Verification
REQ-036 ALU only: alu_valid, rd=5, data=0x1234 -> next cycle w_enabled=1, w_addr=5, w_data=0x1234.
REQ-037 Collision: alu rd=3 data=0xA and LSU rd=4 data=0xB same cycle -> cycle+1 writes x3=0xA, cycle+2 writes x4=0xB; lsu_ready=0 during cycle+1.
REQ-038 Scoreboard: issue long rd=7; dec_rs1=7 -> dec_stall=1 until LSU rd=7 written; stall drops in the w_enabled cycle.
REQ-039 Set/clear race: LSU result for rd=7 written while a new long op issues rd=7 -> pending[7] stays 1.
REQ-040 rd=0: LSU result rd=0 data=0xFFFF -> w_enabled stays 0, instret +1 (macro on).
REQ-041 Reset with skid full and pending[9]=1 -> next cycle pending=0, skid empty, lsu_ready=1 after rst drops.
